// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave: AR addresses are queued in a small FIFO and served
// in order by a four-state FSM that fetches from an external register file.
module axi4_lite_read_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        axi_clk,
  input  logic                        resetn,
  input  logic [ADDR_WIDTH-1:0]       s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [DATA_WIDTH-1:0]       s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic                        reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_rd_idx,
  input  logic [DATA_WIDTH-1:0]       reg_rd_data,
  output logic [7:0]                  err_count
);
  localparam int SH = $clog2(DATA_WIDTH/8);
  localparam int IW = $clog2(NUM_REGS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_e;

  state_e                                  state_q, state_d;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]   fifo_q, fifo_d;
  logic [PW:0]                             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]                   rdata_q, rdata_d;
  logic [1:0]                              rresp_q, rresp_d;
  logic                                    rvalid_q, rvalid_d;
  logic                                    rd_en_q, rd_en_d;
  logic [IW-1:0]                           rd_idx_q, rd_idx_d;
  logic [7:0]                              err_q, err_d;

  logic                  fifo_full, fifo_empty, push, pop;
  logic [ADDR_WIDTH-1:0] head_addr, dec_idx;
  logic                  misaligned, out_of_range;

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // Full blocks acceptance even if the FSM pops on the same edge.
  assign s_arready = resetn && !fifo_full;
  assign push      = s_arvalid && s_arready;
  assign pop       = (state_q == IDLE) && !fifo_empty;

  assign head_addr    = fifo_q[rd_ptr_q[PW-1:0]];
  assign dec_idx      = head_addr >> SH;
  assign misaligned   = |head_addr[SH-1:0];
  assign out_of_range = dec_idx >= ADDR_WIDTH'(NUM_REGS);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    if (push) fifo_d[wr_ptr_q[PW-1:0]] = s_araddr;
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    rd_en_d  = 1'b0;
    rd_idx_d = rd_idx_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (pop) begin
        if (misaligned || out_of_range) begin
          state_d  = RESP;
          rdata_d  = '0;
          rresp_d  = misaligned ? RESP_SLVERR : RESP_DECERR;
          rvalid_d = 1'b1;
        end else begin
          state_d  = FETCH;
          rd_en_d  = 1'b1;
          rd_idx_d = dec_idx[IW-1:0];
        end
      end
      FETCH: state_d = WAIT;
      // Register file answers one cycle after the strobe, i.e. during WAIT.
      WAIT: begin
        state_d  = RESP;
        rdata_d  = reg_rd_data;
        rresp_d  = RESP_OKAY;
        rvalid_d = 1'b1;
      end
      RESP: if (s_rready) begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
        if (rresp_q != RESP_OKAY && err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_idx_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      rd_en_q  <= rd_en_d;
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;
  assign s_rvalid   = rvalid_q;
  assign reg_rd_en  = rd_en_q;
  assign reg_rd_idx = rd_idx_q;
  assign err_count  = err_q;

endmodule
